// File: rtl/prbs7_xnor_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1, XNOR feedback) receive checker.
// Locks after LOCK_CNT clean predictions, then free-runs and counts bit errors.
module prbs7_xnor_checker #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [6:0]       h_q, h_d;
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic exp_bit;
  logic lock_hit;
  logic loss_hit;
  logic err_hit;

  assign exp_bit = ~(h_q[6] ^ h_q[5]);

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      h_q         <= 7'h00;
      fill_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // History and run-length counters
  always_comb begin
    h_d         = h_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lock_hit    = 1'b0;
    loss_hit    = 1'b0;
    err_hit     = 1'b0;
    if (din_valid) begin
      if (state_q == SEARCH) begin
        h_d = {h_q[5:0], din};
        if (fill_cnt_q != 3'd7) begin
          fill_cnt_d = fill_cnt_q + 3'd1;
        end else if ((din == exp_bit) && (h_q != 7'h7F)) begin
          // All-ones is the XNOR lockup state and can never qualify a lock.
          if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
            lock_hit    = 1'b1;
            match_cnt_d = 8'd0;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end else begin
          match_cnt_d = 8'd0;
        end
      end else begin
        // Free-run on the prediction so a corrupted bit never poisons history.
        h_d = {h_q[5:0], exp_bit};
        if (din != exp_bit) begin
          err_hit = 1'b1;
          if (miss_cnt_q == 4'(LOSS_CNT - 1)) begin
            loss_hit    = 1'b1;
            fill_cnt_d  = 3'd0;
            match_cnt_d = 8'd0;
            miss_cnt_d  = 4'd0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end else begin
          miss_cnt_d = 4'd0;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (lock_hit) state_d = LOCKED;
      LOCKED:  if (loss_hit) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Registered outputs
  always_comb begin
    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_hit;
    err_count_d = err_count_q;
    if (clear_cnt) begin
      err_count_d = err_hit ? CNT_W'(1) : '0;
    end else if (err_hit && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed bench for prbs7_xnor_checker: default instance plus a CNT_W=4
// instance sharing the same stimulus to exercise counter saturation.
module tb_prbs7_xnor_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s;

  int checks = 0;
  int errors = 0;
  logic [6:0] gen_s = 7'h01;

  always #5 clk = ~clk;

  prbs7_xnor_checker #(.LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs7_xnor_checker #(.LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear_cnt(clear_cnt),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
  );

  typedef struct {
    logic v;
    logic inv;
    logic clr;
    logic e_locked;
    logic e_pulse;
    int   e_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic raw(input logic v, input logic d, input logic clr);
    din_valid = v;
    din       = d;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic beat(input logic v, input logic inv, input logic clr);
    logic d;
    if (v) begin
      gen_s = {gen_s[5:0], ~(gen_s[6] ^ gen_s[5])};
      d = gen_s[0] ^ inv;
    end else begin
      d = 1'($urandom_range(0, 1));
    end
    raw(v, d, clr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw(1'b0, 1'b0, 1'b0);
    raw(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int vb;
    int iter;
    logic ever_locked;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};

    // Reset state
    do_reset();
    chk("reset_locked", int'(locked), 0);
    chk("reset_pulse", int'(err_pulse), 0);
    chk("reset_count", int'(err_count), 0);
    $display("reset: locked=%b pulse=%b cnt=%0d", locked, err_pulse, err_count);

    // Clean lock from seed 7'h01: locked after valid beat 23, not 22
    gen_s = 7'h01;
    for (int i = 1; i <= 23; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      if (i == 22) chk("lock_not_early", int'(locked), 0);
      if (i == 23) begin
        chk("lock_at_23", int'(locked), 1);
        chk("lock_at_23_sat", int'(locked_s), 1);
      end
    end
    pulses = 0;
    for (int i = 24; i <= 1000; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      if (err_pulse) pulses++;
    end
    chk("clean_pulses", pulses, 0);
    chk("clean_count", int'(err_count), 0);
    chk("clean_locked", int'(locked), 1);
    $display("clean lock: 1000 bits locked=%b cnt=%0d", locked, err_count);

    // Single errors, gaps and coincident clear
    for (int i = 0; i < 13; i++) begin
      beat(tbl[i].v, tbl[i].inv, tbl[i].clr);
      $display("vec %0d: v=%b inv=%b clr=%b locked=%b pulse=%b cnt=%0d",
               i, tbl[i].v, tbl[i].inv, tbl[i].clr, locked, err_pulse, err_count);
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].e_locked));
      chk($sformatf("vec%0d_pulse", i), int'(err_pulse), int'(tbl[i].e_pulse));
      chk($sformatf("vec%0d_count", i), int'(err_count), tbl[i].e_cnt);
      chk($sformatf("vec%0d_count_sat", i), int'(err_count_s), tbl[i].e_cnt);
    end

    // 20 isolated errors: wide counter reaches 21, 4-bit counter saturates at 15
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, 1'b1, 1'b0);
      if (err_pulse) pulses++;
      beat(1'b1, 1'b0, 1'b0);
      if (err_pulse) pulses++;
    end
    chk("iso_pulses", pulses, 20);
    chk("iso_count", int'(err_count), 21);
    chk("iso_count_sat", int'(err_count_s), 15);
    chk("iso_locked", int'(locked), 1);
    $display("isolated errors: cnt=%0d cnt_sat=%0d locked=%b", err_count, err_count_s, locked);

    // Loss of lock on the 4th consecutive mismatch, then relock 23 beats later
    for (int i = 1; i <= 4; i++) begin
      beat(1'b1, 1'b1, 1'b0);
      chk($sformatf("loss%0d_pulse", i), int'(err_pulse), 1);
      chk($sformatf("loss%0d_locked", i), int'(locked), (i < 4) ? 1 : 0);
    end
    chk("loss_count", int'(err_count), 25);
    chk("loss_count_sat", int'(err_count_s), 15);
    $display("loss of lock: locked=%b cnt=%0d", locked, err_count);
    pulses = 0;
    for (int i = 1; i <= 23; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      if (err_pulse) pulses++;
      if (i == 22) chk("relock_not_early", int'(locked), 0);
      if (i == 23) chk("relock_at_23", int'(locked), 1);
    end
    chk("relock_pulses", pulses, 0);
    chk("relock_count", int'(err_count), 25);
    $display("relock: locked=%b cnt=%0d", locked, err_count);

    // Reset while locked, coincident with an erroneous valid beat
    beat(1'b1, 1'b1, 1'b0);
    chk("pre_rst_count", int'(err_count), 26);
    rst = 1'b1;
    beat(1'b1, 1'b1, 1'b0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_count", int'(err_count), 0);
    chk("rst_count_sat", int'(err_count_s), 0);
    rst = 1'b0;
    $display("reset while locked: locked=%b pulse=%b cnt=%0d", locked, err_pulse, err_count);

    // Lockup guard: constant ones never lock
    ever_locked = 1'b0;
    for (int i = 0; i < 100; i++) begin
      raw(1'b1, 1'b1, 1'b0);
      if (locked) ever_locked = 1'b1;
    end
    chk("lockup_locked", int'(ever_locked), 0);
    chk("lockup_count", int'(err_count), 0);
    $display("lockup guard: ever_locked=%b cnt=%0d", ever_locked, err_count);

    // Random valid gaps: lock still lands on the 23rd valid beat
    do_reset();
    gen_s = 7'h4B;
    vb = 0;
    iter = 0;
    while ((vb < 23) && (iter < 1000)) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      beat(v, 1'b0, 1'b0);
      iter++;
      if (v) begin
        vb++;
        if (vb == 22) chk("gap_lock_not_early", int'(locked), 0);
        if (vb == 23) chk("gap_lock_at_23", int'(locked), 1);
      end
    end
    chk("gap_budget", int'(vb), 23);
    beat(1'b0, 1'b0, 1'b0);
    chk("gap_hold_locked", int'(locked), 1);
    chk("gap_count", int'(err_count), 0);
    $display("gapped lock: %0d clocks for %0d valid beats locked=%b", iter, vb, locked);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
